// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Recovers pixel timing from an incoming VGA-style hSync/vSync/rgb stream.
//   Column and line counters are rebuilt from the falling sync edges. The
//   stream is checked line by line and frame by frame against the nominal
//   timing. The receiver reports lock after LOCK_FRAMES consecutive clean
//   frames, and it captures pixels only inside the visible window.
//
// Ports
//   clk          system clock, single domain
//   reset        asynchronous, active-high
//   pix_en       one-clk strobe per pixel tick; everything but frame_start
//                advances only on these edges
//   hSync/vSync  active-low syncs
//   rgb_in       {R,G,B} 4 bits each
//   hCount       recovered column
//   vCount       recovered line
//   bright       pixel is visible and the receiver is locked
//   rgb_out      captured pixel, 0 outside the visible area
//   frame_start  one-clk pulse after every pixel tick that saw a vSync fall
//   locked       timing lock indicator
//   err_count    saturating count of lock losses
//
// Handshake: there is no back-pressure. The receiver samples all inputs on
// every clk edge where pix_en=1. The outputs then stay valid until the next
// such edge. frame_start is the one output that stays high for only one clk.
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [11:0] rgb_in,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VS    = 10'(H_VIS_START);
    localparam logic [9:0] H_VE    = 10'(H_VIS_END);
    localparam logic [9:0] V_VS    = 10'(V_VIS_START);
    localparam logic [9:0] V_VE    = 10'(V_VIS_END);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    state_t      state;
    state_t      state_nxt;
    logic        hs_prev;
    logic        vs_prev;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [9:0]  hcnt_nxt;
    logic [9:0]  vcnt_nxt;
    logic [7:0]  good_frames;
    logic [7:0]  good_nxt;
    logic [7:0]  err_nxt;
    logic        hs_fall;
    logic        vs_fall;
    logic        line_err;
    logic        frame_err;
    logic        sync_err;
    logic        bright_nxt;

    assign hCount = hcnt;
    assign vCount = vcnt;

    always_comb begin
        hs_fall = hs_prev & ~hSync;
        vs_fall = vs_prev & ~vSync;

        // Counter updates. Both counters saturate rather than wrap, so a
        // dead sync input leaves them parked at 1023.
        if (hs_fall)
            hcnt_nxt = 10'd0;
        else if (hcnt == CNT_MAX)
            hcnt_nxt = hcnt;
        else
            hcnt_nxt = hcnt + 10'd1;

        if (vs_fall)
            vcnt_nxt = 10'd0;
        else if (hs_fall && vcnt != CNT_MAX)
            vcnt_nxt = vcnt + 10'd1;
        else
            vcnt_nxt = vcnt;

        // All checks look at the counter values held before this tick's
        // clear. A timeout is flagged on the tick where the counter would
        // step onto H_TOTAL / V_TOTAL.
        line_err  = (hs_fall && hcnt != H_LAST) ||
                    (!hs_fall && hcnt == H_LAST);
        frame_err = (vs_fall && (vcnt != V_LAST || !hs_fall)) ||
                    (hs_fall && !vs_fall && vcnt == V_LAST);
        sync_err  = (state != SEARCH) && (line_err || frame_err);

        state_nxt = state;
        good_nxt  = good_frames;
        err_nxt   = err_count;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = 8'd0;
                end
            end
            ACQUIRE: begin
                if (sync_err) begin
                    state_nxt = SEARCH;
                end else if (vs_fall) begin
                    if (good_frames + 8'd1 >= LOCK_N)
                        state_nxt = LOCKED;
                    good_nxt = good_frames + 8'd1;
                end
            end
            LOCKED: begin
                if (sync_err) begin
                    state_nxt = SEARCH;
                    if (err_count != 8'hFF)
                        err_nxt = err_count + 8'd1;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase

        // Visibility uses the post-tick state. That way the tick that
        // drops lock already shows bright=0.
        bright_nxt = (state_nxt == LOCKED) &&
                     (hcnt_nxt >= H_VS) && (hcnt_nxt < H_VE) &&
                     (vcnt_nxt >= V_VS) && (vcnt_nxt < V_VE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            good_frames <= 8'd0;
            err_count   <= 8'd0;
            bright      <= 1'b0;
            rgb_out     <= 12'h000;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_start <= pix_en & vs_fall;
            if (pix_en) begin
                state       <= state_nxt;
                hs_prev     <= hSync;
                vs_prev     <= vSync;
                hcnt        <= hcnt_nxt;
                vcnt        <= vcnt_nxt;
                good_frames <= good_nxt;
                err_count   <= err_nxt;
                bright      <= bright_nxt;
                rgb_out     <= bright_nxt ? rgb_in : 12'h000;
                locked      <= (state_nxt == LOCKED);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver
//   Directed bench for vga_sync_receiver. It uses a shrunken 24x12 timing so
//   that many frames fit in a short run. hSync is low for 3 columns and vSync
//   is low for 2 lines. Columns 6..19 and lines 3..9 are visible. The
//   generator position (x,y) is the expected hCount/vCount, with (0,0) at
//   the coincident sync falls. pix_en fires on every 4th clk.
module tb_vga_sync_receiver;

    localparam int HT   = 24;
    localparam int VT   = 12;
    localparam int HVS  = 6;
    localparam int HVE  = 20;
    localparam int VVS  = 3;
    localparam int VVE  = 10;
    localparam int HS_W = 3;
    localparam int VS_W = 2;

    logic        clk;
    logic        reset;
    logic        pix_en;
    logic        hSync;
    logic        vSync;
    logic [11:0] rgb_in;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic [11:0] rgb_out;
    logic        frame_start;
    logic        locked;
    logic [7:0]  err_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_lock;
    int   exp_err;

    vga_sync_receiver #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .H_VIS_START (HVS),
        .H_VIS_END   (HVE),
        .V_VIS_START (VVS),
        .V_VIS_END   (VVE),
        .LOCK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hSync       (hSync),
        .vSync       (vSync),
        .rgb_in      (rgb_in),
        .hCount      (hCount),
        .vCount      (vCount),
        .bright      (bright),
        .rgb_out     (rgb_out),
        .frame_start (frame_start),
        .locked      (locked),
        .err_count   (err_count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hCount"},      32'(hCount),      32'd0);
        check({tag, "_vCount"},      32'(vCount),      32'd0);
        check({tag, "_bright"},      32'(bright),      32'd0);
        check({tag, "_rgb_out"},     32'(rgb_out),     32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_locked"},      32'(locked),      32'd0);
        check({tag, "_err_count"},   32'(err_count),   32'd0);
    endtask

    // One pixel tick: three idle clks, then one clk with pix_en high.
    // The task returns on the falling edge after the strobe edge.
    task automatic pix_tick(input logic h, input logic v, input logic [11:0] rgb);
        repeat (3) @(negedge clk);
        hSync  = h;
        vSync  = v;
        rgb_in = rgb;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    function automatic logic [11:0] pattern(input int x, input int y);
        if ((x == 6 || x == 4) && y == 3)
            return 12'hF00;
        return {4'(x), 4'(y), 4'hA};
    endfunction

    // Drive the generator pixel (x,y) and check every output that the
    // bench can predict from its own position and lock expectation.
    task automatic gen_tick(input int x, input int y, input logic vs_low,
                            input bit chk_cnt, input logic exp_fs);
        logic [11:0] rgb;
        logic        exp_b;
        rgb   = pattern(x, y);
        pix_tick(x >= HS_W, (y >= VS_W) && !vs_low, rgb);
        exp_b = exp_lock && x >= HVS && x < HVE && y >= VVS && y < VVE;
        if (chk_cnt) begin
            check("hCount", 32'(hCount), 32'(x));
            check("vCount", 32'(vCount), 32'(y));
        end
        check("bright",      32'(bright),      32'(exp_b));
        check("rgb_out",     32'(rgb_out),     exp_b ? 32'(rgb) : 32'd0);
        check("locked",      32'(locked),      32'(exp_lock));
        check("err_count",   32'(err_count),   32'(exp_err));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    // One full frame. short_y >= 0 makes that line one tick short, and
    // lock is then expected to drop at the next hSync fall.
    task automatic run_frame(input int short_y, input bit lock_here);
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < ((y == short_y) ? HT - 1 : HT); x++) begin
                if (x == 0 && y == 0 && lock_here)
                    exp_lock = 1'b1;
                if (short_y >= 0 && x == 0 && y == short_y + 1) begin
                    exp_lock = 1'b0;
                    exp_err  = exp_err + 1;
                end
                gen_tick(x, y, 1'b0, 1'b1, x == 0 && y == 0);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        pix_en   = 1'b0;
        hSync    = 1'b1;
        vSync    = 1'b1;
        rgb_in   = 12'h000;
        exp_lock = 1'b0;
        exp_err  = 0;

        // Outputs must be zero while reset is held.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Lock comes at the third vSync fall.
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b1);

        // A short line drops lock, and the receiver relocks at the third
        // vSync fall after that.
        run_frame(4, 1'b0);
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b1);

        // hSync stuck high. Lock drops when hcnt steps onto HT, and hCount
        // then saturates at 1023.
        for (int i = 1; i <= 1100; i++) begin
            pix_tick(1'b1, 1'b1, 12'h0FF);
            if (i == 1) begin
                exp_lock = 1'b0;
                exp_err  = exp_err + 1;
            end
            check("stuck_hCount",      32'(hCount), (23 + i > 1023) ? 32'd1023 : 32'(23 + i));
            check("stuck_vCount",      32'(vCount), 32'd11);
            check("stuck_locked",      32'(locked), 32'd0);
            check("stuck_bright",      32'(bright), 32'd0);
            check("stuck_rgb_out",     32'(rgb_out), 32'd0);
            check("stuck_frame_start", 32'(frame_start), 32'd0);
            check("stuck_err_count",   32'(err_count), 32'(exp_err));
        end

        // Relock, take a third error, and relock again.
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b1);
        run_frame(3, 1'b0);
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b1);

        // Partial frame while locked, stopping at the visible pixel (9,5).
        for (int y = 0; y <= 5; y++)
            for (int x = 0; x < ((y == 5) ? 10 : HT); x++)
                gen_tick(x, y, 1'b0, 1'b1, x == 0 && y == 0);

        // With pix_en low, sync activity must be ignored and outputs held.
        hSync = 1'b0;
        vSync = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_hCount",      32'(hCount),      32'd9);
        check("hold_vCount",      32'(vCount),      32'd5);
        check("hold_bright",      32'(bright),      32'd1);
        check("hold_locked",      32'(locked),      32'd1);
        check("hold_frame_start", 32'(frame_start), 32'd0);
        check("hold_err_count",   32'(err_count),   32'd3);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        hSync = 1'b1;
        vSync = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_all_zero("post_reset_idle");
        exp_lock = 1'b0;
        exp_err  = 0;

        // After reset: the first frame enters ACQUIRE. The next frame has
        // an extra vSync fall 5 ticks before the line end, with no hSync
        // fall, which sends the receiver back to SEARCH without counting.
        run_frame(-1, 1'b0);
        for (int y = 0; y < VT; y++)
            for (int x = 0; x < HT; x++) begin
                if (y == VT - 1 && x >= HT - 5) begin
                    gen_tick(x, y, 1'b1, 1'b0, x == HT - 5);
                    check("misalign_hCount", 32'(hCount), 32'(x));
                    check("misalign_vCount", 32'(vCount), 32'd0);
                end else begin
                    gen_tick(x, y, 1'b0, 1'b1, x == 0 && y == 0);
                end
            end
        // vSync is already low at this frame's start, so there is no fall.
        // vcnt runs one line ahead of the generator here.
        for (int y = 0; y < VT; y++)
            for (int x = 0; x < HT; x++) begin
                gen_tick(x, y, 1'b0, 1'b0, 1'b0);
                check("search_hCount", 32'(hCount), 32'(x));
                check("search_vCount", 32'(vCount), 32'(y + 1));
            end
        // SEARCH -> ACQUIRE, then one good frame, then lock.
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_TOTAL 800 pixel ticks per line; V_TOTAL 525 lines per frame
  H_VIS_START 144 first visible column; H_VIS_END 784 first column past visible area
  V_VIS_START 35 first visible line; V_VIS_END 515 first line past visible area
  LOCK_FRAMES 2 consecutive good frames required to lock
REQ-002 Ports (name direction width meaning), one per line:
  clk in 1 system clock, single clock domain
  reset in 1 asynchronous, active-high reset
  pix_en in 1 one-clk strobe, one per pixel tick
  hSync in 1 horizontal sync, active-low
  vSync in 1 vertical sync, active-low
  rgb_in in 12 pixel colour {R[3:0],G[3:0],B[3:0]}
  hCount out 10 recovered column; vCount out 10 recovered line
  bright out 1 recovered visible-area flag
  rgb_out out 12 captured pixel, 0 outside the visible area
  frame_start out 1 one-clk pulse per detected frame start
  locked out 1 timing lock indicator
  err_count out 8 count of lock losses, saturating

Function
REQ-003 Inputs are sampled and state advances only on clk edges where pix_en=1; all registers hold otherwise.
REQ-004 Edge detection: hs_fall = (hs_prev=1 and hSync=0); vs_fall likewise with vs_prev; hs_prev and vs_prev update on each pix_en tick.
REQ-005 hcnt: cleared to 0 on hs_fall, otherwise incremented; saturates at 1023.
REQ-006 vcnt: cleared to 0 on vs_fall; otherwise incremented on hs_fall; saturates at 1023.
REQ-007 Latency: on a pix_en edge, hCount=hcnt, vCount=vcnt, bright and rgb_out all update together and describe the pixel sampled at that edge.
REQ-008 bright=1 iff locked=1, H_VIS_START<=hcnt<H_VIS_END and V_VIS_START<=vcnt<V_VIS_END; rgb_out=rgb_in when bright=1, else 12'h000.
REQ-009 Line error (checked in ACQUIRE/LOCKED): on hs_fall, pre-clear hcnt != H_TOTAL-1; or hcnt reaches H_TOTAL with no hs_fall (timeout, flagged at that tick).
REQ-010 Frame error (checked in ACQUIRE/LOCKED): on vs_fall, pre-clear vcnt != V_TOTAL-1; vs_fall without a coincident hs_fall (misalignment); or vcnt reaches V_TOTAL with no vs_fall.
REQ-011 On simultaneous hs_fall and vs_fall, both checks use pre-clear counter values, then hcnt and vcnt clear to 0.
REQ-012 State machine SEARCH/ACQUIRE/LOCKED; locked=1 only in LOCKED.
REQ-013 SEARCH: no checks; first vs_fall -> ACQUIRE with good_frames=0.
REQ-014 ACQUIRE: each error-free vs_fall increments good_frames; reaching LOCK_FRAMES -> LOCKED on that tick; any line or frame error -> SEARCH.
REQ-015 LOCKED: any line or frame error -> SEARCH and err_count+1, saturating at 255; the errored tick already has bright=0.
REQ-016 frame_start pulses for exactly one clk, on the clk after any pix_en edge with vs_fall, in every state.

Reset
REQ-017 Reset asserts asynchronously at any time, including mid-frame, forcing: state SEARCH; hcnt, vcnt, good_frames and err_count 0; hs_prev and vs_prev 1 (no false edge); all outputs 0.
REQ-018 After reset deasserts, operation resumes on the next pix_en tick.

Verification
REQ-019 Bench scenarios:
  Standard 800x525 stream, pix_en every 4th clk -> locked=1 at the 3rd vs_fall; hCount/vCount equal generator counts every tick thereafter.
  Locked, rgb_in=12'hF00 at (144,35) -> bright=1, rgb_out=12'hF00; at (100,35) -> bright=0, rgb_out=0.
  Locked, one line shortened to 799 ticks -> locked=0 at that hs_fall, err_count=1; relocks at the 3rd subsequent vs_fall.
  Locked, hSync held high -> locked=0 when hcnt reaches 800; frame_start stops.
  vSync fall offset 5 ticks from hSync fall during ACQUIRE -> state SEARCH, err_count stays 0.
  Reset pulse mid-frame while locked, with err_count=3 -> all outputs 0 immediately, without waiting for clk; pix_en held low -> counters hold.
